// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared width default, multiplier state encoding and counter width
package mips_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W     = $clog2(WIDTH_DEF + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/fadder.sv
// rtl/fadder.sv - 1-bit full adder
module fadder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca.sv
// rtl/rca.sv - WIDTH-bit ripple-carry adder built from a fadder chain, carry-in tied low
module rca import mips_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] c;

    assign c[0] = 1'b0;
    assign cout = c[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        fadder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (sum[i]),
            .cout (c[i+1])
        );
    end

endmodule

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - sequential shift-and-add MULT/MULTU producing the HI/LO pair
module mul_seq import mips_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH == WIDTH_DEF) ? CNT_W : $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t state, state_nxt;

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplr;
    logic [WIDTH-1:0]   acc;
    logic               neg;
    logic [CW-1:0]      cnt;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               carry;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;

    // Magnitude of the most negative value wraps to itself, which is correct as unsigned.
    assign mag_a = (is_signed && op_a[WIDTH-1]) ? (~op_a + WIDTH'(1)) : op_a;
    assign mag_b = (is_signed && op_b[WIDTH-1]) ? (~op_b + WIDTH'(1)) : op_b;

    assign addend   = mplr[0] ? mcand : '0;
    assign prod     = {acc, mplr};
    assign prod_fix = neg ? (~prod + (2*WIDTH)'(1)) : prod;

    assign busy = (state != IDLE);

    rca #(.WIDTH(WIDTH)) u_rca (
        .a    (acc),
        .b    (addend),
        .sum  (sum),
        .cout (carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST_STEP) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            mplr  <= '0;
            acc   <= '0;
            neg   <= 1'b0;
            cnt   <= '0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= mag_a;
                        mplr  <= mag_b;
                        neg   <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    // Right shift of {carry, sum, mplr}; the consumed multiplier bit drops out.
                    {acc, mplr} <= {carry, sum, mplr[WIDTH-1:1]};
                    cnt         <= cnt + CW'(1);
                end
                FIX: begin
                    {hi, lo} <= prod_fix;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - self-checking bench for mul_seq
module tb_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mul_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint pa;
        longint pb;
        pa = s ? longint'($signed(a)) : longint'({32'b0, a});
        pb = s ? longint'($signed(b)) : longint'({32'b0, b});
        return 64'(pa * pb);
    endfunction

    // Presents start for one edge, then waits for done; returns inside the done cycle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output int lat);
        start     = 1'b1;
        op_a      = a;
        op_b      = b;
        is_signed = s;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
        is_signed = 1'($urandom);
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int ndone;
        logic [63:0] exp;

        vecs[0] = '{32'd3,        32'd5,        1'b0, 32'h00000000, 32'h0000000F};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{32'hFFFFFFF9, 32'd3,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[3] = '{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000};
        vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000001};
        vecs[5] = '{32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000};

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_hilo", {hi, lo}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, lat);
            check($sformatf("vec%0d_latency", i), lat, 33);
            check($sformatf("vec%0d_hilo", i), {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
            check($sformatf("vec%0d_busy_after", i), busy, 0);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_done_pulse", i), done, 0);
            check($sformatf("vec%0d_hold", i), {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
        end

        // Random back-to-back operations, each start issued during the previous done cycle.
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic        s;
            a = $urandom;
            b = $urandom;
            s = 1'($urandom);
            if (i % 6 == 0) a = 32'h80000000;
            if (i % 7 == 3) b = 32'hFFFFFFFF;
            exp = model(a, b, s);
            run_op(a, b, s, lat);
            check($sformatf("rand%0d_latency", i), lat, 33);
            check($sformatf("rand%0d_hilo a=%0h b=%0h s=%0d", i, a, b, s), {hi, lo}, exp);
        end
        @(posedge clk);
        #1;

        // Start while busy is ignored; a start in the done cycle is accepted.
        @(negedge clk);
        start = 1'b1; op_a = 32'd2; op_b = 32'd2; is_signed = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("busy_mid", busy, 1);
        start = 1'b1; op_a = 32'd9; op_b = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        lat = -1;
        for (int e = 11; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (lat < 0) lat = e;
                if (e == 33) begin
                    check("busy_start_lo", lo, 32'd4);
                    start = 1'b1; op_a = 32'd9; op_b = 32'd9; is_signed = 1'b0;
                end
            end
            if (e == 34) start = 1'b0;
        end
        check("busy_start_ndone", ndone, 1);
        check("busy_start_edge", lat, 33);
        lat = -1;
        for (int e = 41; e <= 80; e++) begin
            @(posedge clk);
            #1;
            if (done && lat < 0) begin
                lat = e;
                check("b2b_lo", lo, 32'h51);
            end
        end
        check("b2b_edge", lat, 67);

        // Reset mid-operation.
        @(negedge clk);
        start = 1'b1; op_a = 32'd3; op_b = 32'd5; is_signed = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hilo", {hi, lo}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("rst_no_done", ndone, 0);
        check("rst_idle", busy, 0);
        run_op(32'd6, 32'd7, 1'b0, lat);
        check("post_rst_latency", lat, 33);
        check("post_rst_lo", {hi, lo}, 64'h2A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
